drop_scheduler: RTL

DROP_SCHEDULER -- requirements
Module: drop_scheduler

---
 rtl/drop_scheduler_pkg.sv | 22 ++
 rtl/drop_scheduler_if.sv | 10 +
 rtl/drop_scheduler_tick_edge.sv | 26 ++
 rtl/drop_scheduler.sv | 118 +++++++++++
 4 files changed

// File: rtl/drop_scheduler_pkg.sv
// Shared types and constants for the falling-piece drop scheduler.
package drop_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    REQ   = 2'd2,
    LOCK  = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ      = 50_000_000;
  // One upstream timer tick is 0.2 s of system clock.
  localparam int unsigned TICK_CYCLES = CLK_HZ / 5;
  localparam int unsigned FAST_LEVEL  = 7;

  // Ticks between automatic drops: 8 at level 0 down to 1 from level 7 up.
  function automatic logic [3:0] drop_interval(input int unsigned lvl);
    if (lvl >= FAST_LEVEL) return 4'd1;
    return 4'(8 - lvl);
  endfunction

endpackage

// File: rtl/drop_scheduler_if.sv
// Drop/lock handshake between the scheduler (master) and the board logic (slave).
interface drop_scheduler_if;
  logic drop_req;
  logic drop_ack;
  logic drop_blocked;
  logic lock;

  modport master (output drop_req, lock, input drop_ack, drop_blocked);
  modport slave  (input drop_req, lock, output drop_ack, drop_blocked);
endinterface

// File: rtl/drop_scheduler_tick_edge.sv
// Turns the upstream 3-bit tick count into a one-cycle tick strobe, ignoring
// the jump caused by our own timer clear.
module tick_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sec,
  input  logic       clr,
  output logic       tick
);

  logic [2:0] sec_q;
  logic       sup;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec_q <= 3'd0;
      sup   <= 1'b0;
    end else begin
      sec_q <= sec;
      sup   <= clr;
    end
  end

  assign tick = (sec != sec_q) && !sup;

endmodule

// File: rtl/drop_scheduler.sv
// Gravity/lock-delay scheduler for the active piece. Optional macro
// SOFT_DROP_EN adds the soft_drop input (forces a 1-tick drop interval).
module drop_scheduler
  import drop_scheduler_pkg::*;
#(
  parameter int unsigned LOCK_TICKS = 3,
  parameter int unsigned LEVEL_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         sec,
  output logic               timer_clr,
  input  logic               run,
  input  logic [LEVEL_W-1:0] level,
`ifdef SOFT_DROP_EN
  input  logic               soft_drop,
`endif
  drop_scheduler_if.master   bif
);

  state_t     state, state_n;
  logic [3:0] tcnt, tcnt_n;
  logic [4:0] tcnt_inc;
  logic [3:0] interval;
  logic       tick;
  logic       req_q, lock_q, clr_q;
  logic       lock_n, clr_n;

  tick_edge u_tick_edge (
    .clk  (clk),
    .rst  (rst),
    .sec  (sec),
    .clr  (clr_q),
    .tick (tick)
  );

  always_comb begin
    interval = drop_interval(32'(level));
`ifdef SOFT_DROP_EN
    if (soft_drop) interval = 4'd1;
`endif
  end

  assign tcnt_inc = {1'b0, tcnt} + 5'd1;

  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    lock_n  = 1'b0;
    clr_n   = 1'b0;
    if (!run) begin
      state_n = IDLE;
      tcnt_n  = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          tcnt_n  = 4'd0;
          clr_n   = 1'b1;
        end
        COUNT: begin
          // >= so a level raised mid-count drops on the very next tick.
          if (tick) begin
            if (tcnt_inc >= {1'b0, interval}) begin
              state_n = REQ;
              tcnt_n  = 4'd0;
            end else begin
              tcnt_n  = tcnt_inc[3:0];
            end
          end
        end
        REQ: begin
          if (bif.drop_ack) begin
            state_n = bif.drop_blocked ? LOCK : COUNT;
            tcnt_n  = 4'd0;
          end
        end
        LOCK: begin
          if (tick) begin
            if (tcnt_inc >= 5'(LOCK_TICKS)) begin
              state_n = COUNT;
              tcnt_n  = 4'd0;
              lock_n  = 1'b1;
              clr_n   = 1'b1;
            end else begin
              tcnt_n  = tcnt_inc[3:0];
            end
          end
        end
        default: begin
          state_n = IDLE;
          tcnt_n  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      tcnt   <= 4'd0;
      req_q  <= 1'b0;
      lock_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      state  <= state_n;
      tcnt   <= tcnt_n;
      req_q  <= (state_n == REQ);
      lock_q <= lock_n;
      clr_q  <= clr_n;
    end
  end

  assign bif.drop_req = req_q;
  assign bif.lock     = lock_q;
  assign timer_clr    = clr_q;

endmodule
